// File: rtl/stdp_pkg.sv
// stdp_pkg: shared types and helpers for the STDP spike generator.
//   fsm_state_t : emitter state (IDLE, DECIDE, LOW, HIGH)
//   decision_t  : per-window weight update decision
//   sat_min     : step count clipped to the available weight headroom
package stdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_LOW    = 2'd2,
        ST_HIGH   = 2'd3
    } fsm_state_t;

    typedef enum logic [1:0] {
        DEC_NONE    = 2'd0,
        DEC_CAPTURE = 2'd1,
        DEC_BACKOFF = 2'd2,
        DEC_SEARCH  = 2'd3
    } decision_t;

    // Increments emitted for a search event.
    localparam int SEARCH_STEPS = 1;

    // Smaller of the requested steps and the room left, never negative.
    function automatic int sat_min(input int steps, input int room);
        int r;
        r = (steps < room) ? steps : room;
        if (r < 0) r = 0;
        return r;
    endfunction

endpackage

// File: rtl/stdp_spike_gen_spike_emitter.sv
// spike_emitter: turns a (count, direction) request into a train of
// active-low spikes on inc/dec, one LOW cycle followed by one HIGH cycle
// per spike.
//   clk, rst   : clock, synchronous active-high reset
//   start      : gamma_start; enters DECIDE, aborting any train in flight
//   count, up  : request, sampled in the DECIDE cycle
//   inc, dec   : spike lines, idle high (registered)
//   busy       : high in DECIDE, LOW and HIGH (registered)
//   state      : current FSM state (debug, also used for weight tracking)
//   dir_up     : direction of the train in flight
module spike_emitter
    import stdp_pkg::*;
#(
    parameter int W_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W_W-1:0] count,
    input  logic           up,
    output logic           inc,
    output logic           dec,
    output logic           busy,
    output fsm_state_t     state,
    output logic           dir_up
);

    logic [W_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            inc       <= 1'b1;
            dec       <= 1'b1;
            busy      <= 1'b0;
            remaining <= '0;
            dir_up    <= 1'b1;
        end else if (start) begin
            // Abort: lines return high now, so the next spike is always
            // preceded by at least one high cycle.
            state <= ST_DECIDE;
            inc   <= 1'b1;
            dec   <= 1'b1;
            busy  <= 1'b1;
        end else begin
            case (state)
                ST_DECIDE: begin
                    if (count == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        remaining <= count;
                        dir_up    <= up;
                        inc       <= ~up;
                        dec       <= up;
                        state     <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    inc   <= 1'b1;
                    dec   <= 1'b1;
                    state <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (remaining == W_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        remaining <= remaining - 1'b1;
                        inc       <= ~dir_up;
                        dec       <= dir_up;
                        state     <= ST_LOW;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stdp_spike_gen.sv
// stdp_spike_gen: observes pre/post spikes of one synapse over a gamma
// window, decides capture/backoff/none and drives the spike-encoded
// inc/dec lines of the FFSR weight counter, tracking a binary shadow weight.
//   clk, rst     : clock, synchronous active-high reset
//   gamma_start  : closes the current window, opens the next
//   in_spike     : pre-synaptic spike pulse
//   out_spike    : post-synaptic spike pulse
//   w_init       : shadow weight loaded while rst is high
//   inc, dec     : active-low spike lines, idle high
//   busy         : spike train pending or in progress
//   wgt          : shadow weight
// Build option: define STDP_SEARCH_EN to turn "input without output" into a
// single saturating increment (SEARCH); otherwise that case does nothing.
module stdp_spike_gen
    import stdp_pkg::*;
#(
    parameter int TIME_W     = 4,
    parameter int W_W        = 3,
    parameter int WMAX       = 7,
    parameter int CAP_STEPS  = 1,
    parameter int BACK_STEPS = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           gamma_start,
    input  logic           in_spike,
    input  logic           out_spike,
    input  logic [W_W-1:0] w_init,
    output logic           inc,
    output logic           dec,
    output logic           busy,
    output logic [W_W-1:0] wgt
);

    localparam logic [TIME_W-1:0] T_MAX = '1;

    logic [TIME_W-1:0] t, t_in, t_out, snap_t_in, snap_t_out;
    logic              in_seen, out_seen, snap_in, snap_out;
    decision_t         decision;
    logic [W_W-1:0]    step_count;
    logic              step_up;
    fsm_state_t        em_state;
    logic              em_up;

    // Window collection. A spike coincident with gamma_start is stamped 0
    // in the new window, so the counter restarts at 1 to keep later spikes
    // strictly ordered after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            t          <= '0;
            t_in       <= '0;
            t_out      <= '0;
            in_seen    <= 1'b0;
            out_seen   <= 1'b0;
            snap_t_in  <= '0;
            snap_t_out <= '0;
            snap_in    <= 1'b0;
            snap_out   <= 1'b0;
        end else if (gamma_start) begin
            t          <= TIME_W'(1);
            snap_t_in  <= t_in;
            snap_t_out <= t_out;
            snap_in    <= in_seen;
            snap_out   <= out_seen;
            in_seen    <= in_spike;
            out_seen   <= out_spike;
            t_in       <= '0;
            t_out      <= '0;
        end else begin
            if (t != T_MAX) t <= t + 1'b1;
            if (in_spike && !in_seen) begin
                in_seen <= 1'b1;
                t_in    <= t;
            end
            if (out_spike && !out_seen) begin
                out_seen <= 1'b1;
                t_out    <= t;
            end
        end
    end

    always_comb begin
        decision = DEC_NONE;
        if (snap_in && snap_out && (snap_t_in <= snap_t_out)) begin
            decision = DEC_CAPTURE;
        end else if (snap_out) begin
            decision = DEC_BACKOFF;
        end
`ifdef STDP_SEARCH_EN
        else if (snap_in) begin
            decision = DEC_SEARCH;
        end
`endif
    end

    // Counts are clipped to the shadow weight so the counter never wraps.
    always_comb begin
        step_count = '0;
        step_up    = 1'b1;
        case (decision)
            DEC_CAPTURE: step_count = W_W'(sat_min(CAP_STEPS, WMAX - int'(wgt)));
            DEC_BACKOFF: begin
                step_count = W_W'(sat_min(BACK_STEPS, int'(wgt)));
                step_up    = 1'b0;
            end
            DEC_SEARCH:  step_count = W_W'(sat_min(SEARCH_STEPS, WMAX - int'(wgt)));
            default: ;
        endcase
    end

    spike_emitter #(.W_W(W_W)) u_emitter (
        .clk    (clk),
        .rst    (rst),
        .start  (gamma_start),
        .count  (step_count),
        .up     (step_up),
        .inc    (inc),
        .dec    (dec),
        .busy   (busy),
        .state  (em_state),
        .dir_up (em_up)
    );

    // Every cycle spent in LOW is a falling edge already seen downstream,
    // so the shadow moves when LOW is left, even if a new gamma_start
    // aborts the train at that moment.
    always_ff @(posedge clk) begin
        if (rst) begin
            wgt <= w_init;
        end else if (em_state == ST_LOW) begin
            wgt <= em_up ? wgt + 1'b1 : wgt - 1'b1;
        end
    end

endmodule

// File: tb/tb_stdp_spike_gen.sv
// Bench for stdp_spike_gen: two instances (CAP/BACK = 1/1 and 3/4) share
// the same stimulus. A window-level model decides each update from the
// first spike offsets and predicts spike counts and the shadow weight.
module tb_stdp_spike_gen;

    localparam int WMAX = 7;
    localparam int TMAX = 15;
`ifdef STDP_SEARCH_EN
    localparam bit SEARCH = 1'b1;
`else
    localparam bit SEARCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       gamma_start = 1'b0;
    logic       in_spike = 1'b0;
    logic       out_spike = 1'b0;
    logic [2:0] w_init = 3'd0;
    logic       inc_o [2];
    logic       dec_o [2];
    logic       busy_o [2];
    logic [2:0] wgt_o [2];

    int checks = 0;
    int failures = 0;

    // Model state
    int  m_wgt [2];
    int  pend_cnt [2];
    bit  pend_up [2];
    int  ticks_since = -1;
    int  win_in = -1;
    int  win_out = -1;
    int  falls [2][2];
    int  base [2][2];
    logic prev [2][2];

    always #5 clk = ~clk;

    stdp_spike_gen #(.TIME_W(4), .W_W(3), .WMAX(7), .CAP_STEPS(1), .BACK_STEPS(1)) dut_a (
        .clk(clk), .rst(rst), .gamma_start(gamma_start), .in_spike(in_spike),
        .out_spike(out_spike), .w_init(w_init), .inc(inc_o[0]), .dec(dec_o[0]),
        .busy(busy_o[0]), .wgt(wgt_o[0])
    );

    stdp_spike_gen #(.TIME_W(4), .W_W(3), .WMAX(7), .CAP_STEPS(3), .BACK_STEPS(4)) dut_b (
        .clk(clk), .rst(rst), .gamma_start(gamma_start), .in_spike(in_spike),
        .out_spike(out_spike), .w_init(w_init), .inc(inc_o[1]), .dec(dec_o[1]),
        .busy(busy_o[1]), .wgt(wgt_o[1])
    );

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int cap_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int back_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count falling edges on the spike lines; both low at once is illegal.
    task automatic sample_lines();
        for (int k = 0; k < 2; k++) begin
            if (prev[k][0] === 1'b1 && inc_o[k] === 1'b0) falls[k][0]++;
            if (prev[k][1] === 1'b1 && dec_o[k] === 1'b0) falls[k][1]++;
            prev[k][0] = inc_o[k];
            prev[k][1] = dec_o[k];
            check($sformatf("u%0d lines_not_both_low", k),
                  {31'd0, (inc_o[k] === 1'b0 && dec_o[k] === 1'b0)}, 32'd0);
        end
    endtask

    // Window rules: first in/out offsets, clipped timestamps, equal = capture.
    task automatic decide(input int k);
        bit hi, ho;
        int ti, to;
        hi = (win_in >= 0);
        ho = (win_out >= 0);
        ti = imin(win_in, TMAX);
        to = imin(win_out, TMAX);
        pend_up[k]  = 1'b1;
        pend_cnt[k] = 0;
        if (hi && ho && ti <= to) begin
            pend_cnt[k] = imin(cap_of(k), WMAX - m_wgt[k]);
        end else if (ho) begin
            pend_up[k]  = 1'b0;
            pend_cnt[k] = imin(back_of(k), m_wgt[k]);
        end else if (hi && SEARCH) begin
            pend_cnt[k] = imin(1, WMAX - m_wgt[k]);
        end
    endtask

    // Called right after a gamma_start edge, d cycles after the previous one.
    // Spikes start at cycles 1,3,5.. after a gamma, so d cycles allow d/2.
    task automatic settle(input int d);
        int em;
        for (int k = 0; k < 2; k++) begin
            em = imin(pend_cnt[k], d / 2);
            check($sformatf("u%0d inc_spikes", k), falls[k][0] - base[k][0], pend_up[k] ? em : 0);
            check($sformatf("u%0d dec_spikes", k), falls[k][1] - base[k][1], pend_up[k] ? 0 : em);
            m_wgt[k] = m_wgt[k] + (pend_up[k] ? em : -em);
            check($sformatf("u%0d wgt_after_train", k), wgt_o[k], m_wgt[k]);
            check($sformatf("u%0d busy_decide", k), busy_o[k], 1);
            check($sformatf("u%0d inc_high_decide", k), inc_o[k], 1);
            check($sformatf("u%0d dec_high_decide", k), dec_o[k], 1);
            base[k][0] = falls[k][0];
            base[k][1] = falls[k][1];
            decide(k);
        end
    endtask

    task automatic tick(input bit g, input bit i, input bit o);
        gamma_start = g;
        in_spike    = i;
        out_spike   = o;
        @(posedge clk);
        #1;
        gamma_start = 1'b0;
        in_spike    = 1'b0;
        out_spike   = 1'b0;
        sample_lines();
        if (g) begin
            settle(ticks_since + 1);
            win_in      = -1;
            win_out     = -1;
            ticks_since = 0;
        end else begin
            ticks_since++;
        end
        if (i && win_in < 0) win_in = ticks_since;
        if (o && win_out < 0) win_out = ticks_since;
    endtask

    task automatic rst_tick(input int w);
        rst    = 1'b1;
        w_init = 3'(w);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample_lines();
        for (int k = 0; k < 2; k++) begin
            m_wgt[k]    = w;
            pend_cnt[k] = 0;
            pend_up[k]  = 1'b1;
            check($sformatf("u%0d rst_inc", k), inc_o[k], 1);
            check($sformatf("u%0d rst_dec", k), dec_o[k], 1);
            check($sformatf("u%0d rst_busy", k), busy_o[k], 0);
            check($sformatf("u%0d rst_wgt", k), wgt_o[k], w);
            base[k][0] = falls[k][0];
            base[k][1] = falls[k][1];
        end
        win_in      = -1;
        win_out     = -1;
        ticks_since = -1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            falls[k][0] = 0; falls[k][1] = 0;
            base[k][0]  = 0; base[k][1]  = 0;
            prev[k][0]  = 1'bx; prev[k][1] = 1'bx;
        end

        // Capture: in at t=2, out at t=5; unit A spike timing checked per cycle.
        rst_tick(3);
        tick(1, 0, 0);
        tick(0, 0, 0); tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 1);
        repeat (4) tick(0, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        check("cap_inc_low", inc_o[0], 0);
        check("cap_dec_idle", dec_o[0], 1);
        tick(0, 0, 0);
        check("cap_inc_back_high", inc_o[0], 1);
        check("cap_wgt_plus1", wgt_o[0], 4);
        check("cap_busy_high", busy_o[0], 1);
        tick(0, 0, 0);
        check("cap_busy_drop", busy_o[0], 0);
        repeat (6) tick(0, 0, 0);

        // Backoff at wgt=0: DECIDE only, busy for one cycle.
        rst_tick(0);
        tick(1, 0, 0);
        tick(0, 0, 1);
        repeat (3) tick(0, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        check("zero_busy_a", busy_o[0], 0);
        check("zero_busy_b", busy_o[1], 0);
        check("zero_wgt_b", wgt_o[1], 0);
        repeat (8) tick(0, 0, 0);

        // Capture near WMAX: unit B asks for 3, only 1 fits.
        rst_tick(6);
        tick(1, 0, 0);
        tick(0, 1, 0); tick(0, 0, 1);
        repeat (2) tick(0, 0, 0);
        tick(1, 0, 0);
        repeat (10) tick(0, 0, 0);
        check("sat_wgt_b", wgt_o[1], 7);
        check("sat_inc_edges_b", falls[1][0] - base[1][0], 1);

        // Same-cycle in/out counts as capture.
        rst_tick(2);
        tick(1, 0, 0);
        tick(0, 0, 0); tick(0, 1, 1);
        repeat (3) tick(0, 0, 0);
        tick(1, 0, 0);
        repeat (10) tick(0, 0, 0);
        check("tie_wgt_a", wgt_o[0], 3);
        check("tie_wgt_b", wgt_o[1], 5);

        // Reset in the middle of a train.
        rst_tick(5);
        tick(1, 0, 0);
        tick(0, 1, 1);
        tick(1, 0, 0);
        tick(0, 0, 0);
        rst_tick(1);

        // Backoff cut short by a new gamma_start after the first spike.
        rst_tick(5);
        tick(1, 0, 0);
        tick(0, 0, 1);
        repeat (3) tick(0, 0, 0);
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 1);
        tick(1, 0, 0);
        check("abort_wgt_b", wgt_o[1], 4);
        repeat (10) tick(0, 0, 0);
        check("abort_next_wgt_a", wgt_o[0], 5);
        check("abort_next_wgt_b", wgt_o[1], 7);

        // Input without output: SEARCH only when enabled.
        rst_tick(4);
        tick(1, 0, 0);
        tick(0, 1, 0);
        repeat (3) tick(0, 0, 0);
        tick(1, 0, 0);
        repeat (10) tick(0, 0, 0);
        check("search_wgt_a", wgt_o[0], SEARCH ? 5 : 4);

        // Random windows: varied lengths (aborts and saturated timestamps).
        for (int n = 0; n < 150; n++) begin
            int len;
            if ($urandom_range(0, 19) == 0) rst_tick($urandom_range(0, 7));
            tick(1'b1, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            len = $urandom_range(0, 21);
            for (int j = 0; j < len; j++) begin
                tick(1'b0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            end
        end
        tick(1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
